// File: rtl/router_pkt_fifo.sv
// Packet-aware synchronous FIFO for one router output port: tagged header entries,
// occupancy/almost-full status, registered pop data. Optional sticky error flags under ROUTER_PKT_FIFO_ERR_EN.
module router_pkt_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = DEPTH - 4
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     soft_reset,
  input  logic                     write_enb,
  input  logic                     sof_in,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     read_enb,
  output logic [WIDTH-1:0]         data_out,
  output logic                     out_valid,
  output logic                     pkt_last,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow_err,
  output logic                     underflow_err,
  output logic                     pkt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]      AF_LEVEL = (AW+1)'(AFULL_THRESH);
  localparam logic [WIDTH-2:0] REM_ONE  = (WIDTH-1)'(1);
  localparam logic [WIDTH-2:0] REM_ZERO = '0;

  logic [WIDTH:0]     r_mem [DEPTH];
  logic [AW:0]        r_wr_ptr;
  logic [AW:0]        r_rd_ptr;
  logic [WIDTH-2:0]   r_rem;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_out_valid;
  logic               r_pkt_last;

  logic               w_flush;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic [AW:0]        w_occ;
  logic [WIDTH:0]     w_rd_word;
  logic               w_rd_sof;
  logic [WIDTH-2:0]   w_hdr_rem;

  assign w_flush   = !resetn || soft_reset;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_occ     = r_wr_ptr - r_rd_ptr;
  assign w_push    = write_enb && !w_full && !w_flush;
  assign w_pop     = read_enb && !w_empty && !w_flush;
  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_sof  = w_rd_word[WIDTH];
  // Header length field sits in data[WIDTH-1:2]; +1 accounts for the trailing parity byte.
  assign w_hdr_rem = {1'b0, w_rd_word[WIDTH-1:2]} + REM_ONE;

  assign empty       = w_empty;
  assign full        = w_full;
  assign occupancy   = w_occ;
  assign almost_full = (w_occ >= AF_LEVEL);
  assign data_out    = r_data_out;
  assign out_valid   = r_out_valid;
  assign pkt_last    = r_pkt_last;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {sof_in, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_rem       <= '0;
      r_data_out  <= '0;
      r_out_valid <= 1'b0;
      r_pkt_last  <= 1'b0;
    end else begin
      r_out_valid <= w_pop;
      r_pkt_last  <= 1'b0;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr   <= r_rd_ptr + PTR_ONE;
        r_data_out <= w_rd_word[WIDTH-1:0];
        if (w_rd_sof) begin
          r_rem <= w_hdr_rem;
        end else if (r_rem != REM_ZERO) begin
          r_rem      <= r_rem - REM_ONE;
          r_pkt_last <= (r_rem == REM_ONE);
        end
      end
    end
  end

`ifdef ROUTER_PKT_FIFO_ERR_EN
  logic r_overflow_err;
  logic r_underflow_err;
  logic r_pkt_err;

  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
      r_pkt_err       <= 1'b0;
    end else begin
      if (write_enb && w_full) r_overflow_err <= 1'b1;
      if (read_enb && w_empty) r_underflow_err <= 1'b1;
      // Truncated packet (header mid-packet) or orphan byte outside any packet.
      if (w_pop && ((w_rd_sof && r_rem != REM_ZERO) || (!w_rd_sof && r_rem == REM_ZERO)))
        r_pkt_err <= 1'b1;
    end
  end

  assign overflow_err  = r_overflow_err;
  assign underflow_err = r_underflow_err;
  assign pkt_err       = r_pkt_err;
`else
  assign overflow_err  = 1'b0;
  assign underflow_err = 1'b0;
  assign pkt_err       = 1'b0;
`endif

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: directed scenarios plus random traffic, all outputs
// compared each cycle against a queue-based packet model.
module tb_router_pkt_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AW    = 4;
`ifdef ROUTER_PKT_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             resetn;
  logic             soft_reset;
  logic             write_enb;
  logic             sof_in;
  logic [WIDTH-1:0] data_in;
  logic             read_enb;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             pkt_last;
  logic             empty;
  logic             full;
  logic             almost_full;
  logic [AW:0]      occupancy;
  logic             overflow_err;
  logic             underflow_err;
  logic             pkt_err;

  router_pkt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .sof_in(sof_in), .data_in(data_in),
    .read_enb(read_enb), .data_out(data_out), .out_valid(out_valid),
    .pkt_last(pkt_last), .empty(empty), .full(full), .almost_full(almost_full),
    .occupancy(occupancy), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .pkt_err(pkt_err)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [WIDTH:0] mq[$];
  int             m_rem;
  bit             m_ov, m_pl, m_ovf, m_udf, m_perr;
  logic [7:0]     m_dout;

  int checks = 0;
  int errors = 0;
  int stepno = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  task automatic model_update(bit we, bit sf, logic [7:0] d, bit re, bit sr);
    logic [WIDTH:0] w;
    bit fullm, emptym;
    if (!resetn || sr) begin
      mq.delete();
      m_rem = 0; m_ov = 0; m_pl = 0; m_dout = 8'h00;
      m_ovf = 0; m_udf = 0; m_perr = 0;
    end else begin
      fullm  = (mq.size() == DEPTH);
      emptym = (mq.size() == 0);
      if (we && fullm) m_ovf = 1;
      if (re && emptym) m_udf = 1;
      m_ov = 0;
      m_pl = 0;
      if (re && !emptym) begin
        w = mq.pop_front();
        m_ov = 1;
        m_dout = w[7:0];
        if (w[8]) begin
          if (m_rem != 0) m_perr = 1;
          m_rem = int'(w[7:2]) + 1;
        end else if (m_rem != 0) begin
          m_pl = (m_rem == 1);
          m_rem = m_rem - 1;
        end else begin
          m_perr = 1;
        end
      end
      if (we && !fullm) mq.push_back({sf, d});
    end
  endtask

  task automatic step(bit we, bit sf, logic [7:0] d, bit re, bit sr);
    write_enb = we; sof_in = sf; data_in = d; read_enb = re; soft_reset = sr;
    model_update(we, sf, d, re, sr);
    @(posedge clock);
    #1;
    stepno++;
    check("data_out", data_out, m_dout);
    check("out_valid", out_valid, m_ov);
    check("pkt_last", pkt_last, m_pl);
    check("empty", empty, mq.size() == 0);
    check("full", full, mq.size() == DEPTH);
    check("almost_full", almost_full, mq.size() >= AFT);
    check("occupancy", occupancy, mq.size());
    check("overflow_err", overflow_err, ERR_EN & m_ovf);
    check("underflow_err", underflow_err, ERR_EN & m_udf);
    check("pkt_err", pkt_err, ERR_EN & m_perr);
  endtask

  task automatic push(bit sf, logic [7:0] d); step(1, sf, d, 0, 0); endtask
  task automatic pop();                       step(0, 0, 8'h00, 1, 0); endtask
  task automatic idle();                      step(0, 0, 8'h00, 0, 0); endtask
  task automatic flush();                     step(0, 0, 8'h00, 0, 1); endtask

  initial begin
    resetn = 1'b0; soft_reset = 1'b0; write_enb = 1'b0;
    sof_in = 1'b0; data_in = '0; read_enb = 1'b0;

    // Reset
    step(1, 0, 8'h77, 1, 0);
    idle();
    check("rst_empty", empty, 1);
    check("rst_occ", occupancy, 0);
    check("rst_valid", out_valid, 0);
    resetn = 1'b1;
    idle();

    // Fill to full, overflow, drain
    for (int i = 1; i <= 16; i++) begin
      push(0, 8'(i));
      if (i == 11) check("af_before", almost_full, 0);
      if (i == 12) check("af_at12", almost_full, 1);
    end
    check("full16", full, 1);
    check("occ16", occupancy, 16);
    push(0, 8'hAA);
    check("occ_after_drop", occupancy, 16);
    for (int i = 1; i <= 16; i++) begin
      pop();
      check("drain_data", data_out, i);
      check("drain_valid", out_valid, 1);
    end
    idle();
    check("drained_empty", empty, 1);
    flush();

    // Packet: header len 3, 3 payload, parity
    push(1, 8'h0C); push(0, 8'h11); push(0, 8'h22); push(0, 8'h33); push(0, 8'h5A);
    for (int i = 0; i < 4; i++) begin
      pop();
      check("pkt_not_last", pkt_last, 0);
    end
    pop();
    check("pkt_last_flag", pkt_last, 1);
    check("pkt_last_data", data_out, 8'h5A);
    idle();

    // Simultaneous push/pop at empty, full, and occupancy 5
    step(1, 0, 8'h3C, 1, 0);
    check("sim_empty_occ", occupancy, 1);
    check("sim_empty_valid", out_valid, 0);
    pop();
    for (int i = 0; i < 16; i++) push(0, 8'(8'h40 + i));
    step(1, 0, 8'hEE, 1, 0);
    check("sim_full_occ", occupancy, 15);
    check("sim_full_data", data_out, 8'h40);
    for (int i = 0; i < 15; i++) begin
      pop();
      check("sim_full_no_ee", data_out == 8'hEE, 0);
    end
    for (int i = 0; i < 5; i++) push(0, 8'(8'h60 + i));
    step(1, 0, 8'h65, 1, 0);
    check("sim_mid_occ", occupancy, 5);
    flush();

    // Wrap-around at low occupancy
    push(0, 8'h01); push(0, 8'h02);
    for (int i = 0; i < 40; i++) step(1, 0, 8'($urandom), 1, $urandom_range(0, 0) != 0);
    flush();

    // soft_reset with occupancy 7 mid-packet
    push(1, 8'h10);
    for (int i = 0; i < 8; i++) push(0, 8'(8'h80 + i));
    pop(); pop();
    check("pre_sr_occ", occupancy, 7);
    flush();
    check("sr_empty", empty, 1);
    check("sr_data", data_out, 0);
    push(1, 8'h04); push(0, 8'h91); push(0, 8'h92);
    pop(); pop();
    check("sr_pkt_first", pkt_last, 0);
    pop();
    check("sr_pkt_second", pkt_last, 1);

    // Error flags: underflow, truncated packet, sticky until soft_reset
    pop();
    check("udf_set", underflow_err, ERR_EN);
    push(1, 8'h08); push(0, 8'h01); push(1, 8'h04); push(0, 8'h02); push(0, 8'h03);
    pop(); pop(); pop();
    check("perr_set", pkt_err, ERR_EN);
    idle(); idle();
    check("perr_hold", pkt_err, ERR_EN);
    flush();
    check("perr_clr", pkt_err, 0);

    // Reset mid-packet, then a fresh packet
    push(1, 8'h08); push(0, 8'hA1); pop(); pop();
    resetn = 1'b0; idle(); resetn = 1'b1;
    push(1, 8'h00); push(0, 8'hB0); pop(); pop();
    check("rst_fresh_last", pkt_last, 1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 55, $urandom_range(0, 3) == 0, 8'($urandom),
           $urandom_range(0, 99) < 50, $urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) begin
        resetn = 1'b0; idle(); resetn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
